// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the execute-stage ALU.
//   - ALU control codes (4 bit) as seen on alu_cnt
//   - ALUOp encodings from main control (3 bit)
//   - R-type funct encodings (6 bit)
//   - execute-unit state encoding
package alu_pkg;

  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_XOR     = 4'b0011;
  localparam logic [3:0] ALU_NOR     = 4'b0100;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam logic [3:0] ALU_SLT     = 4'b0111;
  localparam logic [3:0] ALU_SLL     = 4'b1000;
  localparam logic [3:0] ALU_SRL     = 4'b1001;
  localparam logic [3:0] ALU_SRA     = 4'b1010;
  localparam logic [3:0] ALU_MUL     = 4'b1100;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

  localparam logic [2:0] ALUOP_RTYPE = 3'b000;
  localparam logic [2:0] ALUOP_ADD   = 3'b001;
  localparam logic [2:0] ALUOP_SUB   = 3'b010;
  localparam logic [2:0] ALUOP_AND   = 3'b011;
  localparam logic [2:0] ALUOP_OR    = 3'b100;
  localparam logic [2:0] ALUOP_SLT   = 3'b101;
  localparam logic [2:0] ALUOP_XOR   = 3'b110;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_XOR = 6'h26;
  localparam logic [5:0] FUNCT_NOR = 6'h27;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;
  localparam logic [5:0] FUNCT_SLL = 6'h00;
  localparam logic [5:0] FUNCT_SRL = 6'h02;
  localparam logic [5:0] FUNCT_SRA = 6'h03;
  localparam logic [5:0] FUNCT_MUL = 6'h18;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  // True for control codes that need the iterative datapath.
  function automatic logic is_multicycle(input logic [3:0] cnt);
    return cnt == ALU_MUL;
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: handshake and data bundle of the execute unit.
//   master : issuing stage / consumer side (drives operation + out_ready)
//   slave  : execute unit (drives in_ready, result beat and status)
interface alu_exec_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_op;
  logic [5:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       alu_cnt;
  logic             zero;
  logic             ovf;
  logic             err;
  logic             busy;

  modport master (
    output in_valid, alu_op, funct, a, b, out_ready,
    input  in_ready, out_valid, result, alu_cnt, zero, ovf, err, busy
  );

  modport slave (
    input  in_valid, alu_op, funct, a, b, out_ready,
    output in_ready, out_valid, result, alu_cnt, zero, ovf, err, busy
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational ALUOp/funct -> 4-bit ALU control code.
//   alu_op_i  : ALUOp from main control
//   funct_i   : R-type funct field (used only when alu_op_i is R-type)
//   alu_cnt_o : control code, ALU_ILLEGAL for unsupported encodings
// Kept free of state so the ID stage can reuse it for multi-cycle detection.
module alu_ctrl_decode
  import alu_pkg::*;
#(
  parameter bit MUL_EN = 1'b1
) (
  input  logic [2:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_cnt_o
);

  always_comb begin
    alu_cnt_o = ALU_ILLEGAL;
    unique case (alu_op_i)
      ALUOP_RTYPE: begin
        unique case (funct_i)
          FUNCT_ADD: alu_cnt_o = ALU_ADD;
          FUNCT_SUB: alu_cnt_o = ALU_SUB;
          FUNCT_AND: alu_cnt_o = ALU_AND;
          FUNCT_OR:  alu_cnt_o = ALU_OR;
          FUNCT_XOR: alu_cnt_o = ALU_XOR;
          FUNCT_NOR: alu_cnt_o = ALU_NOR;
          FUNCT_SLT: alu_cnt_o = ALU_SLT;
          FUNCT_SLL: alu_cnt_o = ALU_SLL;
          FUNCT_SRL: alu_cnt_o = ALU_SRL;
          FUNCT_SRA: alu_cnt_o = ALU_SRA;
          FUNCT_MUL: alu_cnt_o = MUL_EN ? ALU_MUL : ALU_ILLEGAL;
          default:   alu_cnt_o = ALU_ILLEGAL;
        endcase
      end
      ALUOP_ADD: alu_cnt_o = ALU_ADD;
      ALUOP_SUB: alu_cnt_o = ALU_SUB;
      ALUOP_AND: alu_cnt_o = ALU_AND;
      ALUOP_OR:  alu_cnt_o = ALU_OR;
      ALUOP_SLT: alu_cnt_o = ALU_SLT;
      ALUOP_XOR: alu_cnt_o = ALU_XOR;
      default:   alu_cnt_o = ALU_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with registered result beat.
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   bus      : alu_exec_unit_if.slave
//              in_valid/in_ready  operation handshake (alu_op, funct, a, b)
//              out_valid/out_ready result handshake (result, alu_cnt,
//              zero, ovf, err); busy is high while multiplying
// Single-cycle ops deliver one edge after accept; MUL is a shift-add loop
// of WIDTH steps, delivering WIDTH+1 edges after accept.
//
// state    | meaning
// ST_IDLE  | accepting; single-cycle results load straight to output
// ST_MUL   | iterating shift-add, in_ready low, busy high
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter bit          MUL_EN = 1'b1
) (
  input logic            clk,
  input logic            rst,
  alu_exec_unit_if.slave bus
);

  localparam int unsigned SHAMT_W = $clog2(WIDTH);
  localparam logic [SHAMT_W:0] MUL_CYCLES = (SHAMT_W+1)'(WIDTH);
  localparam logic [SHAMT_W:0] CNT_LAST   = (SHAMT_W+1)'(1);
  localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHAMT_W:0] count_q, count_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       alu_cnt_q, alu_cnt_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic [3:0]       dec_cnt;
  logic             in_ready;
  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic [WIDTH-1:0] acc_step;

  alu_ctrl_decode #(
    .MUL_EN (MUL_EN)
  ) u_dec (
    .alu_op_i  (bus.alu_op),
    .funct_i   (bus.funct),
    .alu_cnt_o (dec_cnt)
  );

  // A new op may enter only when the output register is free this cycle.
  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  // SUB shares the adder by adding the two's complement of b.
  assign b_eff = (dec_cnt == ALU_SUB) ? (~bus.b + ONE) : bus.b;
  assign sum   = bus.a + b_eff;
  assign shamt = bus.b[SHAMT_W-1:0];

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    unique case (dec_cnt)
      ALU_AND: alu_res = bus.a & bus.b;
      ALU_OR:  alu_res = bus.a | bus.b;
      ALU_XOR: alu_res = bus.a ^ bus.b;
      ALU_NOR: alu_res = ~(bus.a | bus.b);
      ALU_ADD, ALU_SUB: begin
        alu_res = sum;
        alu_ovf = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) &&
                  (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      ALU_SLL: alu_res = bus.a << shamt;
      ALU_SRL: alu_res = bus.a >> shamt;
      ALU_SRA: alu_res = $unsigned($signed(bus.a) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    // A held beat drains on out_ready; a new load below overrides this.
    out_valid_d = out_valid_q && !bus.out_ready;
    result_d    = result_q;
    alu_cnt_d   = alu_cnt_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    err_d       = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_multicycle(dec_cnt)) begin
            state_d  = ST_MUL;
            mcand_d  = bus.a;
            mplier_d = bus.b;
            acc_d    = '0;
            count_d  = MUL_CYCLES;
          end else begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            alu_cnt_d   = dec_cnt;
            zero_d      = (alu_res == '0);
            ovf_d       = alu_ovf;
            err_d       = (dec_cnt == ALU_ILLEGAL);
          end
        end
      end
      ST_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q - 1'b1;
        // Final step writes the output directly, saving a cycle.
        if (count_q == CNT_LAST) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b1;
          result_d    = acc_step;
          alu_cnt_d   = ALU_MUL;
          zero_d      = (acc_step == '0);
          ovf_d       = 1'b0;
          err_d       = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      alu_cnt_q   <= 4'b0000;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      alu_cnt_q   <= alu_cnt_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.alu_cnt   = alu_cnt_q;
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;
  assign bus.err       = err_q;
  assign bus.busy      = (state_q == ST_MUL);

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vectors with a scoreboard queue; a monitor
// pops and compares each delivered result beat.
module tb_alu_exec_unit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   cycle;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  cnt;
    logic        z;
    logic        o;
    logic        e;
  } exp_t;

  exp_t sb[$];

  alu_exec_unit_if #(.WIDTH(32)) bus ();
  alu_exec_unit_if #(.WIDTH(32)) bus0 ();

  alu_exec_unit #(.WIDTH(32), .MUL_EN(1'b1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  alu_exec_unit #(.WIDTH(32), .MUL_EN(1'b0)) u_dut_nomul (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a beat transfers at the next rising edge when valid && ready.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL beat_unexpected: got result %0h cnt %0h with empty queue",
                 bus.result, bus.alu_cnt);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({bus.result, bus.alu_cnt, bus.zero, bus.ovf, bus.err} !== e) begin
          n_fail++;
          $display("FAIL beat: got result %0h cnt %0h z %0b o %0b e %0b expected result %0h cnt %0h z %0b o %0b e %0b",
                   bus.result, bus.alu_cnt, bus.zero, bus.ovf, bus.err,
                   e.res, e.cnt, e.z, e.o, e.e);
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] xres, input logic [3:0] xcnt,
                       input logic xz, input logic xo, input logic xe);
    logic ok;
    int   n;
    exp_t e;
    e = '{res: xres, cnt: xcnt, z: xz, o: xo, e: xe};
    sb.push_back(e);
    bus.alu_op   = op;
    bus.funct    = fn;
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      void'(sb.pop_back());
      chk("issue_accept_timeout", 64'(ok), 64'(1));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_queue_empty", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    int busy_cnt;
    int rdy_cnt;
    int c0;
    n_checks = 0;
    n_fail   = 0;
    cycle    = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.alu_op = '0; bus.funct = '0; bus.a = '0; bus.b = '0;
    bus0.in_valid = 1'b0; bus0.out_ready = 1'b1;
    bus0.alu_op = '0; bus0.funct = '0; bus0.a = '0; bus0.b = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({bus.out_valid, bus.result, bus.alu_cnt, bus.zero,
                               bus.ovf, bus.err, bus.busy}), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 64'(bus.in_ready), 64'(1));
    @(posedge clk);
    #1;

    // Single-cycle ops
    issue(3'b000, 6'h20, 32'd5, 32'd7, 32'd12, 4'b0010, 0, 0, 0);
    issue(3'b010, 6'h00, 32'h1234, 32'h1234, 32'd0, 4'b0110, 1, 0, 0);
    issue(3'b001, 6'h00, 32'h7FFFFFFF, 32'd1, 32'h80000000, 4'b0010, 0, 1, 0);
    issue(3'b011, 6'h00, 32'hF0F0, 32'hFF00, 32'hF000, 4'b0000, 0, 0, 0);
    issue(3'b100, 6'h00, 32'hF0F0, 32'h0F00, 32'hFFF0, 4'b0001, 0, 0, 0);
    issue(3'b110, 6'h00, 32'hFF00, 32'h0FF0, 32'hF0F0, 4'b0011, 0, 0, 0);
    issue(3'b000, 6'h27, 32'h0, 32'hFFFF0000, 32'h0000FFFF, 4'b0100, 0, 0, 0);
    issue(3'b101, 6'h00, 32'hFFFFFFFF, 32'd1, 32'd1, 4'b0111, 0, 0, 0);
    issue(3'b000, 6'h2A, 32'd1, 32'hFFFFFFFF, 32'd0, 4'b0111, 1, 0, 0);
    issue(3'b000, 6'h02, 32'h80000000, 32'd4, 32'h08000000, 4'b1001, 0, 0, 0);
    issue(3'b000, 6'h03, 32'h80000000, 32'd4, 32'hF8000000, 4'b1010, 0, 0, 0);
    issue(3'b000, 6'h03, 32'h80000000, 32'h21, 32'hC0000000, 4'b1010, 0, 0, 0);
    issue(3'b000, 6'h22, 32'h80000000, 32'd1, 32'h7FFFFFFF, 4'b0110, 0, 1, 0);
    issue(3'b111, 6'h20, 32'd5, 32'd3, 32'd0, 4'b1111, 1, 0, 1);
    issue(3'b000, 6'h3F, 32'd5, 32'd3, 32'd0, 4'b1111, 1, 0, 1);
    drain();

    // MUL latency: busy for WIDTH cycles, out_valid on edge WIDTH+1
    issue(3'b000, 6'h18, 32'd6, 32'd7, 32'd42, 4'b1100, 0, 0, 0);
    busy_cnt = 0;
    rdy_cnt  = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.in_ready) rdy_cnt++;
    end
    chk("mul_busy_cycles", 64'(busy_cnt), 64'(32));
    chk("mul_in_ready_low", 64'(rdy_cnt), 64'(0));
    @(negedge clk);
    chk("mul_out_valid_latency", 64'({bus.out_valid, bus.busy}), 64'(2'b10));
    @(posedge clk);
    #1;
    issue(3'b000, 6'h18, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 4'b1100, 0, 0, 0);
    issue(3'b000, 6'h18, 32'h10000, 32'h10000, 32'd0, 4'b1100, 1, 0, 0);
    drain();

    // Output hold under back-pressure
    bus.out_ready = 1'b0;
    issue(3'b000, 6'h00, 32'd1, 32'd4, 32'd16, 4'b1000, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_stable", 64'({bus.out_valid, bus.in_ready, bus.result}),
          64'({1'b1, 1'b0, 32'd16}));
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    drain();

    // Back-to-back throughput
    c0 = cycle;
    issue(3'b001, 6'h00, 32'd1, 32'd2, 32'd3, 4'b0010, 0, 0, 0);
    issue(3'b001, 6'h00, 32'd10, 32'd20, 32'd30, 4'b0010, 0, 0, 0);
    issue(3'b001, 6'h00, 32'hFFFFFFFF, 32'd1, 32'd0, 4'b0010, 1, 0, 0);
    issue(3'b001, 6'h00, 32'h80000000, 32'h80000000, 32'd0, 4'b0010, 1, 1, 0);
    chk("b2b_cycles", 64'(cycle - c0), 64'(4));
    drain();

    // MUL_EN=0 build rejects funct 0x18
    bus0.alu_op = 3'b000; bus0.funct = 6'h18; bus0.a = 32'd6; bus0.b = 32'd7;
    bus0.in_valid = 1'b1;
    @(negedge clk);
    chk("nomul_in_ready", 64'(bus0.in_ready), 64'(1));
    @(posedge clk);
    #1;
    bus0.in_valid = 1'b0;
    @(negedge clk);
    chk("nomul_illegal", 64'({bus0.out_valid, bus0.err, bus0.alu_cnt, bus0.busy, bus0.result}),
        64'({1'b1, 1'b1, 4'b1111, 1'b0, 32'd0}));
    @(posedge clk);
    #1;

    // Reset during MUL aborts immediately
    issue(3'b000, 6'h18, 32'd3, 32'd3, 32'd9, 4'b1100, 0, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    sb.delete();
    chk("rst_mid_mul", 64'({bus.busy, bus.out_valid}), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release_in_ready", 64'(bus.in_ready), 64'(1));
    chk("rst_release_outputs", 64'({bus.out_valid, bus.result, bus.alu_cnt, bus.zero,
                                     bus.ovf, bus.err, bus.busy}), 64'(0));
    @(posedge clk);
    #1;
    issue(3'b000, 6'h20, 32'd100, 32'd23, 32'd123, 4'b0010, 0, 0, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
